game_countdown_timer: RTL and testbench

Upstream stage of the game FSM: counts game seconds down from a preset and issues the one-cycle timer_expired pulse the FSM consumes to leave RUNNING. Runs entirely in the clkIn domain. The slow 1 Hz incrementClk is synchronised and edge-detected into single-cycle ticks. Also drives the remaining time as binary and BCD digits for the seven-segment display path.

---
 rtl/game_countdown_timer.sv | 163 ++++++++++++++++
 tb/tb_game_countdown_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/game_countdown_timer.sv
// Game countdown timer: synchronises the 1 Hz game clock into ticks and counts
// GAME_TIME seconds down to an expiry pulse. Optional blink: WARN_BLINK_EN.
//
// Ports:
//   clkIn, reset (async, active-low), incrementClk (async 1 Hz data),
//   startGame / pause / stop controls,
//   time_left (binary), time_tens / time_ones (BCD), running,
//   timer_expired (1-cycle pulse), warn (last-ten-seconds blink).
module game_countdown_timer #(
  parameter int GAME_TIME   = 30,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       incrementClk,
  input  logic       startGame,
  input  logic       pause,
  input  logic       stop,
  output logic [5:0] time_left,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       running,
  output logic       timer_expired,
  output logic       warn
);

  if (GAME_TIME < 1 || GAME_TIME > 63) begin : g_bad_time
    $error("GAME_TIME must be 1..63");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..3");
  end

  localparam logic [5:0] LOAD_BIN  = 6'(GAME_TIME);
  localparam logic [3:0] LOAD_TENS = 4'(GAME_TIME / 10);
  localparam logic [3:0] LOAD_ONES = 4'(GAME_TIME % 10);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick_q;

  logic [5:0] tl_q, tl_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       exp_d;
  logic       exp_q;
  logic       run_q;

  // Registered edge detect: tick lands SYNC_STAGES+1 cycles after the rise.
  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], incrementClk};
      edge_q <= sync_q[SYNC_STAGES-1];
      tick_q <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tl_d    = tl_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    exp_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      tl_d    = '0;
      tens_d  = '0;
      ones_d  = '0;
    end else if (startGame) begin
      state_d = RUN;
      tl_d    = LOAD_BIN;
      tens_d  = LOAD_TENS;
      ones_d  = LOAD_ONES;
    end else begin
      unique case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick_q) begin
            tl_d = tl_q - 6'd1;
            if (ones_q == 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end else begin
              ones_d = ones_q - 4'd1;
            end
            if (tl_q == 6'd1) begin
              state_d = EXPIRED;
              exp_d   = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!pause) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tl_q    <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      exp_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tl_q    <= tl_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      exp_q   <= exp_d;
      run_q   <= (state_d == RUN) || (state_d == PAUSED);
    end
  end

  assign time_left     = tl_q;
  assign time_tens     = tens_q;
  assign time_ones     = ones_q;
  assign running       = run_q;
  assign timer_expired = exp_q;

`ifdef WARN_BLINK_EN
  logic warn_q;
  logic load_evt;
  logic dec_evt;

  assign load_evt = startGame & ~stop;
  // Only a plain decrement toggles; the expiring tick leaves RUN.
  assign dec_evt  = ~stop & ~startGame & (state_q == RUN) & ~pause
                  & tick_q & (tl_q > 6'd1);

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      warn_q <= 1'b0;
    end else if (state_d != RUN || load_evt) begin
      warn_q <= 1'b0;
    end else if (dec_evt && tl_d <= 6'd10) begin
      warn_q <= ~warn_q;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer with GAME_TIME=12.
// Checks reset, countdown, pause, restart-on-final-tick, stop and reset.
module tb_game_countdown_timer;

  localparam int GT = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       incrementClk = 1'b0;
  logic       startGame = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [5:0] time_left;
  logic [3:0] time_tens;
  logic [3:0] time_ones;
  logic       running;
  logic       timer_expired;
  logic       warn;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  int exp_misalign = 0;

  game_countdown_timer #(.GAME_TIME(GT), .SYNC_STAGES(2)) dut (
    .clkIn(clk),
    .reset(reset),
    .incrementClk(incrementClk),
    .startGame(startGame),
    .pause(pause),
    .stop(stop),
    .time_left(time_left),
    .time_tens(time_tens),
    .time_ones(time_ones),
    .running(running),
    .timer_expired(timer_expired),
    .warn(warn)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (timer_expired === 1'b1) begin
      exp_cnt++;
      if (time_left !== 6'd0) exp_misalign++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_pulse();
    incrementClk = 1'b1;
    cyc(5);
    incrementClk = 1'b0;
    cyc(3);
  endtask

  task automatic start_pulse();
    startGame = 1'b1;
    cyc(1);
    startGame = 1'b0;
    cyc(1);
  endtask

  function automatic logic warn_exp(input int v);
`ifdef WARN_BLINK_EN
    if (v == 0 || v > 10) return 1'b0;
    return 1'((11 - v) & 1);
`else
    return (v < 0);
`endif
  endfunction

  initial begin
    int e0;
    int v;
    reset = 1'b0;
    #12;
    chk("rst_tl", 32'(time_left), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_exp", 32'(timer_expired), 0);
    chk("rst_warn", 32'(warn), 0);
    #8;
    reset = 1'b1;
    cyc(2);
    chk("idle_tl", 32'(time_left), 0);
    chk("idle_bcd", {24'd0, time_tens, time_ones}, 0);
    chk("idle_run", 32'(running), 0);

    // Full countdown
    start_pulse();
    chk("load_tl", 32'(time_left), GT);
    chk("load_bcd", {24'd0, time_tens, time_ones}, 32'h12);
    chk("load_run", 32'(running), 1);
    for (int i = 1; i <= GT; i++) begin
      tick_pulse();
      v = GT - i;
      chk("cd_tl", 32'(time_left), 32'(v));
      chk("cd_tens", 32'(time_tens), 32'(v / 10));
      chk("cd_ones", 32'(time_ones), 32'(v % 10));
      chk("cd_warn", 32'(warn), 32'(warn_exp(v)));
    end
    chk("exp_cnt", 32'(exp_cnt), 1);
    chk("exp_align", 32'(exp_misalign), 0);
    chk("exp_run", 32'(running), 0);
    cyc(4);
    chk("exp_hold", 32'(time_left), 0);

    // Pause drops ticks
    start_pulse();
    repeat (3) tick_pulse();
    chk("pre_pause", 32'(time_left), GT - 3);
    pause = 1'b1;
    cyc(1);
    repeat (4) tick_pulse();
    chk("paused_tl", 32'(time_left), GT - 3);
    chk("paused_run", 32'(running), 1);
    chk("paused_warn", 32'(warn), 0);
    pause = 1'b0;
    cyc(1);
    repeat (2) tick_pulse();
    chk("post_pause", 32'(time_left), GT - 5);
    chk("post_bcd", {24'd0, time_tens, time_ones}, 32'h07);

    // Restart on the same cycle as the final tick
    start_pulse();
    repeat (GT - 1) tick_pulse();
    chk("at_one", 32'(time_left), 1);
    e0 = exp_cnt;
    incrementClk = 1'b1;
    cyc(3);
    startGame = 1'b1;
    cyc(1);
    startGame = 1'b0;
    cyc(4);
    incrementClk = 1'b0;
    cyc(3);
    chk("race_tl", 32'(time_left), GT);
    chk("race_bcd", {24'd0, time_tens, time_ones}, 32'h12);
    chk("race_exp", 32'(exp_cnt - e0), 0);
    chk("race_run", 32'(running), 1);

    // Stop mid-count
    tick_pulse();
    tick_pulse();
    chk("pre_stop", 32'(time_left), GT - 2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(2);
    chk("stop_tl", 32'(time_left), 0);
    chk("stop_bcd", {24'd0, time_tens, time_ones}, 0);
    chk("stop_run", 32'(running), 0);
    chk("stop_exp", 32'(exp_cnt - e0), 0);
    tick_pulse();
    chk("idle_tick", 32'(time_left), 0);

    // Asynchronous reset mid-count
    start_pulse();
    tick_pulse();
    chk("pre_rst", 32'(time_left), GT - 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_tl", 32'(time_left), 0);
    chk("arst_run", 32'(running), 0);
    chk("arst_bcd", {24'd0, time_tens, time_ones}, 0);
    cyc(1);
    reset = 1'b1;
    cyc(2);
    chk("arst_exp", 32'(exp_cnt - e0), 0);
    chk("arst_warn", 32'(warn), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
